// File: rtl/light_out_arbiter.sv
// Arbitrates the lamp light-select code between the game engine and the processor.
// Each grant holds its code for HOLD_CYCLES cycles; the processor is guaranteed a slot after STARVE_LIMIT lost decisions.
module light_out_arbiter #(
    parameter int  CODE_W       = 3,
    parameter int  HOLD_CYCLES  = 8,
    parameter int  STARVE_LIMIT = 3,
    localparam int HOLD_W       = $clog2(HOLD_CYCLES + 1),
    localparam int STARVE_W     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                game_req,
    input  logic [CODE_W-1:0]   game_code,
    input  logic                proc_req,
    input  logic [CODE_W-1:0]   proc_code,
    output logic                game_ack,
    output logic                proc_ack,
    output logic [CODE_W-1:0]   light_sel,
    output logic                light_valid,
    output logic [1:0]          owner,
    output logic [1:0]          dbg_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GAME = 2'b01,
        ST_PROC = 2'b10
    } state_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [CODE_W-1:0]   r_light_sel;
    logic                r_game_ack;
    logic                r_proc_ack;

    state_t              w_next_state;
    logic [HOLD_W-1:0]   w_next_hold;
    logic [STARVE_W-1:0] w_next_starve;
    logic [CODE_W-1:0]   w_next_sel;
    logic                w_next_game_ack;
    logic                w_next_proc_ack;
    logic                w_decide;
    logic                w_proc_wins;

    // Decisions happen while idle or on the last cycle of a grant; inputs are ignored otherwise.
    assign w_decide    = (r_state == ST_IDLE) || (r_hold_cnt == '0);
    assign w_proc_wins = proc_req && (!game_req || (r_starve_cnt == STARVE_W'(STARVE_LIMIT)));

    always_comb begin
        w_next_state    = r_state;
        w_next_hold     = (r_hold_cnt != '0) ? r_hold_cnt - HOLD_W'(1) : '0;
        w_next_starve   = r_starve_cnt;
        w_next_sel      = r_light_sel;
        w_next_game_ack = 1'b0;
        w_next_proc_ack = 1'b0;
        if (w_decide) begin
            w_next_hold = '0;
            if (!enable) begin
                w_next_state = ST_IDLE;
                w_next_sel   = '0;
            end else if (w_proc_wins) begin
                w_next_state    = ST_PROC;
                w_next_sel      = proc_code;
                w_next_hold     = HOLD_W'(HOLD_CYCLES - 1);
                w_next_proc_ack = 1'b1;
                w_next_starve   = '0;
            end else if (game_req) begin
                w_next_state    = ST_GAME;
                w_next_sel      = game_code;
                w_next_hold     = HOLD_W'(HOLD_CYCLES - 1);
                w_next_game_ack = 1'b1;
                if (!proc_req) begin
                    w_next_starve = '0;
                end else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                    w_next_starve = r_starve_cnt + STARVE_W'(1);
                end
            end else begin
                // Reaching here means proc_req is low (a lone proc_req would have won).
                w_next_state  = ST_IDLE;
                w_next_sel    = '0;
                w_next_starve = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_starve_cnt <= '0;
            r_light_sel  <= '0;
            r_game_ack   <= 1'b0;
            r_proc_ack   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_hold_cnt   <= w_next_hold;
            r_starve_cnt <= w_next_starve;
            r_light_sel  <= w_next_sel;
            r_game_ack   <= w_next_game_ack;
            r_proc_ack   <= w_next_proc_ack;
        end
    end

    assign game_ack       = r_game_ack;
    assign proc_ack       = r_proc_ack;
    assign light_sel      = r_light_sel;
    assign light_valid    = (r_state != ST_IDLE);
    assign owner          = r_state;
    assign dbg_state      = r_state;
    assign dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_light_out_arbiter.sv
// Directed bench for light_out_arbiter: a vector table for reset/hold/withdraw behaviour,
// plus hand-written sequences for rotation, enable drop and mid-grant reset.
module tb_light_out_arbiter;

    localparam int CODE_W = 3;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              game_req;
    logic [CODE_W-1:0] game_code;
    logic              proc_req;
    logic [CODE_W-1:0] proc_code;
    logic              game_ack;
    logic              proc_ack;
    logic [CODE_W-1:0] light_sel;
    logic              light_valid;
    logic [1:0]        owner;
    logic [1:0]        dbg_state;
    logic [1:0]        dbg_starve_cnt;

    int total = 0;
    int bad   = 0;

    light_out_arbiter #(
        .CODE_W      (CODE_W),
        .HOLD_CYCLES (8),
        .STARVE_LIMIT(3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .game_req      (game_req),
        .game_code     (game_code),
        .proc_req      (proc_req),
        .proc_code     (proc_code),
        .game_ack      (game_ack),
        .proc_ack      (proc_ack),
        .light_sel     (light_sel),
        .light_valid   (light_valid),
        .owner         (owner),
        .dbg_state     (dbg_state),
        .dbg_starve_cnt(dbg_starve_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       greq;
        logic [2:0] gcode;
        logic       preq;
        logic [2:0] pcode;
        logic       e_gack;
        logic       e_pack;
        logic [2:0] e_sel;
        logic       e_valid;
        logic [1:0] e_owner;
        logic [1:0] e_starve;
    } vec_t;

    vec_t vecs[19];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int gack, input int pack, input int sel,
                           input int valid, input int own);
        chk({tag, ".game_ack"}, int'(game_ack), gack);
        chk({tag, ".proc_ack"}, int'(proc_ack), pack);
        chk({tag, ".light_sel"}, int'(light_sel), sel);
        chk({tag, ".light_valid"}, int'(light_valid), valid);
        chk({tag, ".owner"}, int'(owner), own);
    endtask

    task automatic drive(input logic rst, input logic en, input logic greq, input logic [2:0] gc,
                         input logic preq, input logic [2:0] pc);
        reset     = rst;
        enable    = en;
        game_req  = greq;
        game_code = gc;
        proc_req  = preq;
        proc_code = pc;
    endtask

    initial begin
        int pack_cnt;
        drive(1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 3'd3);

        // Reset with both requests high, release into a game grant of code 5,
        // game_code changes to 2 mid-hold, re-grant at cycle 9, then a one-cycle
        // proc_req pulse during the second hold that must never be acknowledged.
        vecs[0]  = '{1, 1, 1, 5, 1, 3,  0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 5, 1, 3,  0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 5, 0, 3,  1, 0, 5, 1, 1, 0};
        vecs[3]  = '{0, 1, 1, 5, 0, 3,  0, 0, 5, 1, 1, 0};
        for (int i = 4; i <= 9; i++) vecs[i] = '{0, 1, 1, 2, 0, 3,  0, 0, 5, 1, 1, 0};
        vecs[10] = '{0, 1, 1, 2, 0, 3,  1, 0, 2, 1, 1, 0};
        vecs[11] = '{0, 1, 1, 2, 1, 6,  0, 0, 2, 1, 1, 0};
        for (int i = 12; i <= 17; i++) vecs[i] = '{0, 1, 1, 2, 0, 6,  0, 0, 2, 1, 1, 0};
        vecs[18] = '{0, 1, 0, 2, 0, 6,  0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].greq, vecs[i].gcode, vecs[i].preq, vecs[i].pcode);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_gack, vecs[i].e_pack, vecs[i].e_sel,
                    vecs[i].e_valid, vecs[i].e_owner);
            chk($sformatf("vec%0d.starve", i), int'(dbg_starve_cnt), vecs[i].e_starve);
        end

        // Both requests held: game wins three windows, then proc, repeating.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 3'd6);
        pack_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            int w;
            int pos;
            int own;
            tick();
            w   = k / 8;
            pos = k % 8;
            own = ((w % 4) == 3) ? 2 : 1;
            if (proc_ack) pack_cnt++;
            chk_all($sformatf("rot%0d", k), (pos == 0 && own == 1) ? 1 : 0,
                    (pos == 0 && own == 2) ? 1 : 0, (own == 1) ? 1 : 6, 1, own);
            chk($sformatf("rot%0d.starve", k), int'(dbg_starve_cnt),
                ((w % 4) == 3) ? 0 : (w % 4) + 1);
        end
        chk("rot.proc_ack_count", pack_cnt, 2);

        // Enable dropped at proc grant cycle 2: grant completes, then idle with no acks.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd4);
        tick();
        chk_all("en.c1", 0, 1, 4, 1, 2);
        drive(1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd5);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk_all($sformatf("en.c%0d", c), 0, 0, 4, 1, 2);
        end
        for (int c = 9; c <= 14; c++) begin
            tick();
            chk_all($sformatf("en.c%0d", c), 0, 0, 0, 0, 0);
        end
        chk("en.starve", int'(dbg_starve_cnt), 0);

        // Reset at game grant cycle 4, then re-grant one cycle after release.
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0);
        tick();
        chk_all("rst.c1", 1, 0, 7, 1, 1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk_all($sformatf("rst.c%0d", c), 0, 0, 7, 1, 1);
        end
        drive(1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0);
        tick();
        chk_all("rst.mid", 0, 0, 0, 0, 0);
        chk("rst.mid.state", int'(dbg_state), 0);
        drive(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0);
        tick();
        chk_all("rst.regrant", 1, 0, 7, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Acks must never coincide.
    always @(negedge clock) begin
        if (game_ack && proc_ack) begin
            bad++;
            total++;
            $display("FAIL ack_exclusive actual=both expected=one at %0t", $time);
        end
    end

endmodule
